// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: instruction intake, register-file read/writeback taps
// and the operand bundle handed to the consumer.
interface operand_fetch_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [31:0]       in_instr;
  logic              in_writes_ra;
  logic              in_ready;
  logic [3:0]        rf_read_sel1;
  logic [3:0]        rf_read_sel2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic              wb_valid;
  logic [3:0]        wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_opcode;
  logic [3:0]        out_dest;
  logic [DATA_W-1:0] out_opa;
  logic [DATA_W-1:0] out_opb;
  logic [15:0]       stall_count;

  modport slave (
    input  in_valid, in_instr, in_writes_ra,
    input  rf_read_data1, rf_read_data2,
    input  wb_valid, wb_sel, wb_data,
    input  out_ready,
    output in_ready, rf_read_sel1, rf_read_sel2,
    output out_valid, out_opcode, out_dest, out_opa, out_opb, stall_count
  );

  modport master (
    output in_valid, in_instr, in_writes_ra,
    output rf_read_data1, rf_read_data2,
    output wb_valid, wb_sel, wb_data,
    output out_ready,
    input  in_ready, rf_read_sel1, rf_read_sel2,
    input  out_valid, out_opcode, out_dest, out_opa, out_opb, stall_count
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: latches one instruction, waits out RAW hazards against a busy-bit
// scoreboard, captures operands (with writeback forwarding) and holds them until consumed.
module operand_fetch #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  operand_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_HAZARD = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        ir_opcode_q, ir_opcode_d;
  logic [3:0]        ir_ra_q, ir_ra_d;
  logic [3:0]        ir_rb_q, ir_rb_d;
  logic [3:0]        ir_rc_q, ir_rc_d;
  logic              ir_wr_q, ir_wr_d;
  logic [15:0]       busy_q, busy_d;
  logic [15:0]       stall_q, stall_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [3:0]        dest_q, dest_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;

  logic              fwd_a_s, fwd_b_s;
  logic              blk_a_s, blk_b_s;
  logic              capture_s;
  logic [15:0]       clr_mask_s, set_mask_s;

  always_comb begin
    state_d     = state_q;
    ir_opcode_d = ir_opcode_q;
    ir_ra_d     = ir_ra_q;
    ir_rb_d     = ir_rb_q;
    ir_rc_d     = ir_rc_q;
    ir_wr_d     = ir_wr_q;
    stall_d     = stall_q;
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    dest_d      = dest_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    capture_s   = 1'b0;

    // A pending writeback to a busy source releases it in the same cycle it is read.
    fwd_a_s = bus.wb_valid && (bus.wb_sel == ir_rb_q);
    fwd_b_s = bus.wb_valid && (bus.wb_sel == ir_rc_q);
    blk_a_s = busy_q[ir_rb_q] && !fwd_a_s;
    blk_b_s = busy_q[ir_rc_q] && !fwd_b_s;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          ir_opcode_d = bus.in_instr[31:27];
          ir_ra_d     = bus.in_instr[26:23];
          ir_rb_d     = bus.in_instr[22:19];
          ir_rc_d     = bus.in_instr[18:15];
          ir_wr_d     = bus.in_writes_ra;
          state_d     = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ, S_HAZARD: begin
        if (blk_a_s || blk_b_s) begin
          state_d = S_HAZARD;
          if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
          end else begin
            stall_d = stall_q;
          end
        end else begin
          capture_s   = 1'b1;
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          opcode_d    = ir_opcode_q;
          dest_d      = ir_ra_q;
          opa_d       = fwd_a_s ? bus.wb_data : bus.rf_read_data1;
          opb_d       = fwd_b_s ? bus.wb_data : bus.rf_read_data2;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Set is applied after clear so a capture marking ra busy wins over a same-cycle writeback.
    clr_mask_s = bus.wb_valid ? (16'd1 << bus.wb_sel) : 16'd0;
    set_mask_s = (capture_s && ir_wr_q) ? (16'd1 << ir_ra_q) : 16'd0;
    busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ir_opcode_q <= 5'd0;
      ir_ra_q     <= 4'd0;
      ir_rb_q     <= 4'd0;
      ir_rc_q     <= 4'd0;
      ir_wr_q     <= 1'b0;
      busy_q      <= 16'd0;
      stall_q     <= 16'd0;
      out_valid_q <= 1'b0;
      opcode_q    <= 5'd0;
      dest_q      <= 4'd0;
      opa_q       <= {DATA_W{1'b0}};
      opb_q       <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ir_opcode_q <= ir_opcode_d;
      ir_ra_q     <= ir_ra_d;
      ir_rb_q     <= ir_rb_d;
      ir_rc_q     <= ir_rc_d;
      ir_wr_q     <= ir_wr_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      dest_q      <= dest_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.rf_read_sel1 = ir_rb_q;
  assign bus.rf_read_sel2 = ir_rc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_opcode   = opcode_q;
  assign bus.out_dest     = dest_q;
  assign bus.out_opa      = opa_q;
  assign bus.out_opb      = opb_q;
  assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: table-driven vectors plus hand-written hazard,
// backpressure, collision, reset and saturation sequences, checked through a scoreboard queue.
module tb_operand_fetch;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_W(DATA_W)) bus ();
  operand_fetch #(.DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] rf [16];
  assign bus.rf_read_data1 = rf[bus.rf_read_sel1];
  assign bus.rf_read_data2 = rf[bus.rf_read_sel2];

  typedef struct {
    logic [4:0]  opcode;
    logic [3:0]  dest;
    logic [31:0] opa;
    logic [31:0] opb;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        wr;
    logic [31:0] exp_opa;
    logic [31:0] exp_opb;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input logic wr, input logic [31:0] ea,
                       input logic [31:0] eb, input bit push);
    exp_t e;
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("issue_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid     = 1'b1;
    bus.in_instr     = {op, ra, rb, rc, 15'h5A5A};
    bus.in_writes_ra = wr;
    tick();
    bus.in_valid     = 1'b0;
    bus.in_writes_ra = 1'b0;
    if (push) begin
      e.opcode = op;
      e.dest   = ra;
      e.opa    = ea;
      e.opb    = eb;
      sb.push_back(e);
    end
  endtask

  task automatic expect_bundle(input string name);
    exp_t e;
    check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_opcode"}, {27'd0, bus.out_opcode}, {27'd0, e.opcode});
      check({name, "_dest"}, {28'd0, bus.out_dest}, {28'd0, e.dest});
      check({name, "_opa"}, bus.out_opa, e.opa);
      check({name, "_opb"}, bus.out_opb, e.opb);
    end
  endtask

  task automatic consume(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_drop_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic wb_tick(input logic [3:0] sel, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_sel   = sel;
    bus.wb_data  = data;
    tick();
    bus.wb_valid = 1'b0;
    rf[sel]      = data;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{op: 5'h01, ra: 4'd1,  rb: 4'd2,  rc: 4'd3,  wr: 1'b0, exp_opa: 32'h11, exp_opb: 32'h22};
    vecs[1] = '{op: 5'h1F, ra: 4'd15, rb: 4'd15, rc: 4'd0,  wr: 1'b0, exp_opa: 32'hEE, exp_opb: 32'hFFFF_FFEF};
    vecs[2] = '{op: 5'h0A, ra: 4'd0,  rb: 4'd9,  rc: 4'd9,  wr: 1'b0, exp_opa: 32'h88, exp_opb: 32'h88};
    vecs[3] = '{op: 5'h10, ra: 4'd10, rb: 4'd1,  rc: 4'd14, wr: 1'b1, exp_opa: 32'h0,  exp_opb: 32'hDD};

    for (int i = 0; i < 16; i++) rf[i] = 32'(i * 17 - 17);
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_instr     = 32'd0;
    bus.in_writes_ra = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_sel       = 4'd0;
    bus.wb_data      = 32'd0;
    bus.out_ready    = 1'b0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_sel1", {28'd0, bus.rf_read_sel1}, 32'd0);
    check("rst_sel2", {28'd0, bus.rf_read_sel2}, 32'd0);
    check("rst_stall", {16'd0, bus.stall_count}, 32'd0);
    check("rst_opa", bus.out_opa, 32'd0);
    check("rst_opb", bus.out_opb, 32'd0);
    check("rst_opcode", {27'd0, bus.out_opcode}, 32'd0);
    check("rst_dest", {28'd0, bus.out_dest}, 32'd0);
    reset = 1'b0;
    tick();

    // Unstalled vectors: exact two-cycle latency from accept to out_valid.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].wr,
            vecs[i].exp_opa, vecs[i].exp_opb, 1'b1);
      check("vec_read_valid", {31'd0, bus.out_valid}, 32'd0);
      check("vec_sel1", {28'd0, bus.rf_read_sel1}, {28'd0, vecs[i].rb});
      check("vec_sel2", {28'd0, bus.rf_read_sel2}, {28'd0, vecs[i].rc});
      tick();
      expect_bundle("vec");
      check("vec_stall", {16'd0, bus.stall_count}, 32'd0);
      consume("vec");
      check("vec_retain_opa", bus.out_opa, vecs[i].exp_opa);
    end

    // RAW stall on r5, released by same-cycle writeback forwarding.
    issue(5'h02, 4'd5, 4'd2, 4'd3, 1'b1, 32'h11, 32'h22, 1'b1);
    tick();
    expect_bundle("raw_prod");
    consume("raw_prod");
    issue(5'h03, 4'd8, 4'd5, 4'd3, 1'b0, 32'hABCD, 32'h22, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("raw_stalled", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    check("raw_stall_pre", {16'd0, bus.stall_count}, 32'd4);
    wb_tick(4'd5, 32'hABCD);
    expect_bundle("raw");
    check("raw_stall_cnt", {16'd0, bus.stall_count}, 32'd4);
    consume("raw");

    // Backpressure: bundle must hold steady while out_ready is low.
    issue(5'h04, 4'd2, 4'd9, 4'd15, 1'b0, 32'h88, 32'hEE, 1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_opa", bus.out_opa, 32'h88);
      check("bp_opb", bus.out_opb, 32'hEE);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    expect_bundle("bp");
    consume("bp");

    // Set/clear collision on r7: busy must survive the coincident writeback.
    issue(5'h06, 4'd7, 4'd2, 4'd3, 1'b1, 32'h11, 32'h22, 1'b1);
    wb_tick(4'd7, 32'h77);
    expect_bundle("coll_prod");
    consume("coll_prod");
    issue(5'h07, 4'd0, 4'd7, 4'd7, 1'b0, 32'h7777, 32'h7777, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("coll_stalled", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    check("coll_stall_cnt", {16'd0, bus.stall_count}, 32'd7);
    wb_tick(4'd7, 32'h7777);
    expect_bundle("coll");
    consume("coll");

    // Reset while stalled on r4 drops the instruction and clears the scoreboard.
    issue(5'h08, 4'd4, 4'd1, 4'd1, 1'b1, 32'h0, 32'h0, 1'b1);
    tick();
    expect_bundle("rh_prod");
    consume("rh_prod");
    issue(5'h09, 4'd3, 4'd4, 4'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    check("rh_stall_pre", {16'd0, bus.stall_count}, 32'd9);
    #1 reset = 1'b1;
    #1;
    check("rh_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rh_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rh_stall", {16'd0, bus.stall_count}, 32'd0);
    check("rh_sel1", {28'd0, bus.rf_read_sel1}, 32'd0);
    check("rh_dest", {28'd0, bus.out_dest}, 32'd0);
    tick();
    reset = 1'b0;
    issue(5'h09, 4'd3, 4'd4, 4'd4, 1'b0, 32'h33, 32'h33, 1'b1);
    check("rh_read_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    expect_bundle("rh");
    check("rh_no_stall", {16'd0, bus.stall_count}, 32'd0);
    consume("rh");

    // Saturation: keep r6 busy long enough to overflow a 16-bit counter.
    issue(5'h0B, 4'd6, 4'd1, 4'd1, 1'b1, 32'h0, 32'h0, 1'b1);
    tick();
    expect_bundle("sat_prod");
    consume("sat_prod");
    issue(5'h0C, 4'd0, 4'd6, 4'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (65534) tick();
    check("sat_fffe", {16'd0, bus.stall_count}, 32'hFFFE);
    tick();
    check("sat_ffff", {16'd0, bus.stall_count}, 32'hFFFF);
    repeat (64) tick();
    check("sat_no_wrap", {16'd0, bus.stall_count}, 32'hFFFF);
    check("sat_valid", {31'd0, bus.out_valid}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 DATA_W, 32, operand and register-file data width; instruction word fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_instr  input  32  instruction: [31:27] opcode, [26:23] ra (dest), [22:19] rb (src A), [18:15] rc (src B).
REQ-006 in_writes_ra  input  1  offered instruction writes ra.
REQ-007 in_ready  output  1  instruction accepted when in_valid && in_ready.
REQ-008 rf_read_sel1  output  4  register-file read select A, driven with latched rb.
REQ-009 rf_read_sel2  output  4  register-file read select B, driven with latched rc.
REQ-010 rf_read_data1  input  DATA_W  combinational read data for sel1.
REQ-011 rf_read_data2  input  DATA_W  combinational read data for sel2.
REQ-012 wb_valid  input  1  register-file write this cycle; mirrors the RF write_enable.
REQ-013 wb_sel  input  4  register written; mirrors the RF write_sel.
REQ-014 wb_data  input  DATA_W  data written; mirrors the RF write_data.
REQ-015 out_valid  output  1  operand bundle valid.
REQ-016 out_ready  input  1  consumer accepts bundle when out_valid && out_ready.
REQ-017 out_opcode  output  5  latched opcode.
REQ-018 out_dest  output  4  latched ra.
REQ-019 out_opa  output  DATA_W  operand A.
REQ-020 out_opb  output  DATA_W  operand B.
REQ-021 stall_count  output  16  saturating count of hazard-stall cycles.

Function
REQ-022 FSM states IDLE, READ, HAZARD, HOLD; in_ready = 1 only in IDLE.
REQ-023 IDLE: on in_valid latch in_instr and in_writes_ra into IR, go READ; otherwise stay.
REQ-024 rf_read_sel1/2 driven from IR rb/rc in every state; 0 after reset until first accept.
REQ-025 Scoreboard: 16 busy bits; source s is blocked iff busy[s] && !(wb_valid && wb_sel == s).
REQ-026 READ/HAZARD: if rb or rc blocked -> HAZARD, stall_count += 1 (saturates at 0xFFFF); else capture -> HOLD.
REQ-027 Capture: operand = wb_data if wb_valid && wb_sel == source, else rf_read_data; applied independently to A and B.
REQ-028 Capture: out_opcode/out_dest loaded from IR; if IR writes_ra, set busy[ra].
REQ-029 Any cycle: wb_valid clears busy[wb_sel]; if the same register is set by capture in that cycle, set wins.
REQ-030 Hazard check uses busy before this cycle's set, so rb == ra or rc == ra does not self-block.
REQ-031 HOLD: out_valid = 1; outputs stable until out_ready; on out_ready -> IDLE, out_valid = 0 next cycle.
REQ-032 Minimum latency: accept (cycle 0) -> READ (cycle 1) -> out_valid asserted cycle 2; throughput 1 per 3 cycles unstalled.
REQ-033 out_* data retain last captured value after handoff.

Reset
REQ-034 Reset asserted (any state, any time) -> IDLE immediately, in-flight instruction dropped, no handshake completed.
REQ-035 Reset values: out_valid 0, out_opcode/out_dest/out_opa/out_opb 0, rf_read_sel1/2 0, all busy bits 0, stall_count 0, IR 0; in_ready 1 after release.

Verification
REQ-036 Basic: RF r2 = 0x11, r3 = 0x22; accept instr rb=2, rc=3 -> out_valid at cycle 2, out_opa 0x11, out_opb 0x22, stall_count 0.
REQ-037 RAW stall: accept ra=5 writes; consume; accept rb=5 -> stays in HAZARD 4 cycles; wb_valid wb_sel=5 wb_data=0xABCD -> same-cycle capture out_opa 0xABCD, stall_count 4.
REQ-038 Backpressure: out_ready low 10 cycles in HOLD -> out_valid and operands stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-039 Set/clear collision: capture with ra=7 writes while wb_valid wb_sel=7 -> busy[7] remains 1, next reader of r7 stalls.
REQ-040 Reset mid-HAZARD: busy[4] set, stalled on r4, reset pulsed -> IDLE, busy all 0, stall_count 0, out_valid 0.
REQ-041 Saturation: hold hazard 70000 cycles -> stall_count 0xFFFF, no wrap.
